// File: rtl/snn_ctrl_pkg.sv
// Shared parameters, sequencer state encoding and rate-coding threshold helper
// for the SNN inference sequencer.
package snn_ctrl_pkg;

    localparam int unsigned IMAGE_SIZE      = 256;
    localparam int unsigned IMAGE_SIZE_BITS = 8;
    localparam int unsigned PIXEL_MAX_VALUE = 255;
    localparam int unsigned PIXEL_BITS      = 8;
    localparam int unsigned NUM_STEPS       = 4;
    localparam int unsigned DIGIT_BITS      = 8;

    localparam int unsigned STEP_BITS = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int unsigned THR_BITS  = PIXEL_BITS + 1;
    localparam int unsigned STEP      = (PIXEL_MAX_VALUE + 1) / NUM_STEPS;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        READ,
        EVAL,
        SEND,
        NEXT,
        TSEND,
        WAIT
    } seq_state_t;

    // Threshold falls by STEP each timestep so brighter pixels spike earlier and more often.
    function automatic logic [THR_BITS-1:0] spike_thr(input logic [STEP_BITS-1:0] t);
        spike_thr = THR_BITS'(PIXEL_MAX_VALUE + 1) - THR_BITS'((32'(t) + 32'd1) * STEP);
    endfunction

endpackage

// File: rtl/rate_encoder.sv
// Deterministic threshold rate coder: decides whether a pixel spikes at a timestep.
module rate_encoder
    import snn_ctrl_pkg::*;
(
    input  logic [PIXEL_BITS-1:0] pixel,
    input  logic [STEP_BITS-1:0]  step,
    output logic                  spike_c
);

    assign spike_c = (pixel != '0) && ({1'b0, pixel} >= spike_thr(step));

endmodule

// File: rtl/snn_inference_sequencer.sv
// Sequences one SNN inference per image: clear core, stream rate-coded spikes for
// NUM_STEPS timesteps, then hand the core's classification back to the AXI side.
module snn_inference_sequencer
    import snn_ctrl_pkg::*;
(
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       NEW_IMAGE,
    output logic [IMAGE_SIZE_BITS-1:0] IMG_RADDR,
    input  logic [PIXEL_BITS-1:0]      IMG_RDATA,
    output logic                       CORE_CLR,
    output logic [IMAGE_SIZE_BITS-1:0] SPK_ADDR,
    output logic                       SPK_TS_END,
    output logic                       SPK_VALID,
    input  logic                       SPK_READY,
    input  logic                       CORE_DONE,
    input  logic [DIGIT_BITS-1:0]      CORE_DIGIT,
    output logic                       COPROCESSOR_RDY,
    output logic [DIGIT_BITS-1:0]      INFERED_DIGIT,
    output logic                       BUSY
);

    localparam logic [IMAGE_SIZE_BITS-1:0] ADDR_LAST = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);
    localparam logic [STEP_BITS-1:0]       T_LAST    = STEP_BITS'(NUM_STEPS - 1);

    seq_state_t                 state, state_next;
    logic [IMAGE_SIZE_BITS-1:0] addr, addr_next;
    logic [STEP_BITS-1:0]       t, t_next;
    logic                       pending, pending_next;
    logic                       nimg_q;
    logic                       start;
    logic                       spike_c;

    logic [IMAGE_SIZE_BITS-1:0] raddr_next;
    logic                       clr_next;
    logic [IMAGE_SIZE_BITS-1:0] spk_addr_next;
    logic                       ts_end_next;
    logic                       valid_next;
    logic                       rdy_next;
    logic [DIGIT_BITS-1:0]      digit_next;
    logic                       busy_next;

    assign start = NEW_IMAGE & ~nimg_q;

    rate_encoder u_rate_encoder (
        .pixel   (IMG_RDATA),
        .step    (t),
        .spike_c (spike_c)
    );

    // State, counters and all registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state           <= IDLE;
            addr            <= '0;
            t               <= '0;
            pending         <= 1'b0;
            nimg_q          <= 1'b0;
            IMG_RADDR       <= '0;
            CORE_CLR        <= 1'b0;
            SPK_ADDR        <= '0;
            SPK_TS_END      <= 1'b0;
            SPK_VALID       <= 1'b0;
            COPROCESSOR_RDY <= 1'b0;
            INFERED_DIGIT   <= '0;
            BUSY            <= 1'b0;
        end else begin
            state           <= state_next;
            addr            <= addr_next;
            t               <= t_next;
            pending         <= pending_next;
            nimg_q          <= NEW_IMAGE;
            IMG_RADDR       <= raddr_next;
            CORE_CLR        <= clr_next;
            SPK_ADDR        <= spk_addr_next;
            SPK_TS_END      <= ts_end_next;
            SPK_VALID       <= valid_next;
            COPROCESSOR_RDY <= rdy_next;
            INFERED_DIGIT   <= digit_next;
            BUSY            <= busy_next;
        end
    end

    // Next state; outputs are derived from the state being entered so they register cleanly.
    always_comb begin
        state_next    = state;
        addr_next     = addr;
        t_next        = t;
        pending_next  = pending | (start & (state != IDLE));
        raddr_next    = IMG_RADDR;
        spk_addr_next = SPK_ADDR;
        ts_end_next   = SPK_TS_END;
        rdy_next      = COPROCESSOR_RDY;
        digit_next    = INFERED_DIGIT;

        case (state)
            IDLE: begin
                if (start || pending) begin
                    state_next   = CLEAR;
                    pending_next = 1'b0;
                    rdy_next     = 1'b0;
                end
            end
            CLEAR: begin
                t_next     = '0;
                addr_next  = '0;
                state_next = READ;
            end
            READ: state_next = EVAL;
            EVAL: begin
                if (spike_c) begin
                    state_next    = SEND;
                    spk_addr_next = addr;
                    ts_end_next   = 1'b0;
                end else begin
                    state_next = NEXT;
                end
            end
            SEND: begin
                if (SPK_READY) state_next = NEXT;
            end
            NEXT: begin
                if (addr == ADDR_LAST) begin
                    state_next    = TSEND;
                    spk_addr_next = '0;
                    ts_end_next   = 1'b1;
                end else begin
                    addr_next  = addr + IMAGE_SIZE_BITS'(1);
                    state_next = READ;
                end
            end
            TSEND: begin
                if (SPK_READY) begin
                    if (t == T_LAST) begin
                        state_next = WAIT;
                    end else begin
                        t_next     = t + STEP_BITS'(1);
                        addr_next  = '0;
                        state_next = READ;
                    end
                end
            end
            WAIT: begin
                if (CORE_DONE) begin
                    digit_next = CORE_DIGIT;
                    rdy_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_next == READ) raddr_next = addr_next;
        clr_next   = (state_next == CLEAR);
        valid_next = (state_next == SEND) || (state_next == TSEND);
        busy_next  = (state_next != IDLE);
    end

endmodule

// File: tb/tb_snn_inference_sequencer.sv
// Self-checking bench for snn_inference_sequencer: an event-list model of the rate-coded
// spike stream plus directed checks of the start/result handshake and reset behaviour.
module tb_snn_inference_sequencer;

    typedef struct packed {
        logic [7:0] a;
        logic       ts;
    } ev_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       NEW_IMAGE = 1'b0;
    logic [7:0] IMG_RADDR;
    logic [7:0] IMG_RDATA = 8'd0;
    logic       CORE_CLR;
    logic [7:0] SPK_ADDR;
    logic       SPK_TS_END;
    logic       SPK_VALID;
    logic       SPK_READY = 1'b1;
    logic       CORE_DONE = 1'b0;
    logic [7:0] CORE_DIGIT = 8'd0;
    logic       COPROCESSOR_RDY;
    logic [7:0] INFERED_DIGIT;
    logic       BUSY;

    logic [7:0] enc_p = 8'd0;
    logic [1:0] enc_t = 2'd0;
    logic       enc_s;

    logic [7:0] img [256];
    ev_t        exp_q [$];

    int n_checks = 0;
    int n_err    = 0;
    int clr_cnt = 0, spk_cnt = 0, ts_cnt = 0, clr_at_first = 0, valid_seen = 0;
    int rdy_mode = 0;  // 0: always ready, 1: pseudo-random, 2: never ready
    logic       hold_prev = 1'b0, hold_ts = 1'b0, prev_clr = 1'b0;
    logic [7:0] hold_addr = 8'd0;

    snn_inference_sequencer dut (
        .CLK             (CLK),
        .RST             (RST),
        .NEW_IMAGE       (NEW_IMAGE),
        .IMG_RADDR       (IMG_RADDR),
        .IMG_RDATA       (IMG_RDATA),
        .CORE_CLR        (CORE_CLR),
        .SPK_ADDR        (SPK_ADDR),
        .SPK_TS_END      (SPK_TS_END),
        .SPK_VALID       (SPK_VALID),
        .SPK_READY       (SPK_READY),
        .CORE_DONE       (CORE_DONE),
        .CORE_DIGIT      (CORE_DIGIT),
        .COPROCESSOR_RDY (COPROCESSOR_RDY),
        .INFERED_DIGIT   (INFERED_DIGIT),
        .BUSY            (BUSY)
    );

    rate_encoder u_enc (
        .pixel   (enc_p),
        .step    (enc_t),
        .spike_c (enc_s)
    );

    always #5 CLK = ~CLK;

    // Image buffer with one cycle of read latency.
    always @(posedge CLK) IMG_RDATA <= img[IMG_RADDR];

    always @(posedge CLK) begin
        #1;
        case (rdy_mode)
            0:       SPK_READY = 1'b1;
            1:       SPK_READY = 1'($urandom_range(0, 1));
            default: SPK_READY = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_spike(input int p, input int t);
        return (p != 0) && (p >= 256 - (t + 1) * (256 / 4));
    endfunction

    task automatic build_events();
        for (int t = 0; t < 4; t++) begin
            for (int a = 0; a < 256; a++)
                if (model_spike(int'(img[a]), t)) exp_q.push_back('{a: 8'(a), ts: 1'b0});
            exp_q.push_back('{a: 8'd0, ts: 1'b1});
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic zero_counts();
        clr_cnt = 0; spk_cnt = 0; ts_cnt = 0; clr_at_first = 0;
    endtask

    task automatic wait_ts(input int target, input string name);
        int n;
        n = 0;
        while (ts_cnt < target && n < 20000) begin
            tick(1);
            n++;
        end
        check(name, 32'(ts_cnt), 32'(target));
    endtask

    task automatic pulse_done(input logic [7:0] d);
        CORE_DIGIT = d;
        CORE_DONE  = 1'b1;
        tick(1);
        CORE_DONE  = 1'b0;
    endtask

    task automatic new_edge();
        NEW_IMAGE = 1'b0;
        tick(1);
        NEW_IMAGE = 1'b1;
        tick(1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_raddr"}, 32'(IMG_RADDR), 0);
        check({tag, "_clr"}, 32'(CORE_CLR), 0);
        check({tag, "_spk_addr"}, 32'(SPK_ADDR), 0);
        check({tag, "_ts_end"}, 32'(SPK_TS_END), 0);
        check({tag, "_valid"}, 32'(SPK_VALID), 0);
        check({tag, "_rdy"}, 32'(COPROCESSOR_RDY), 0);
        check({tag, "_digit"}, 32'(INFERED_DIGIT), 0);
        check({tag, "_busy"}, 32'(BUSY), 0);
    endtask

    // Compare process: accepted events against the model, handshake stability, clear pulses.
    always @(negedge CLK) begin
        if (RST) begin
            hold_prev = 1'b0;
            prev_clr  = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 32'(SPK_VALID), 1);
                check("hold_addr", 32'(SPK_ADDR), 32'(hold_addr));
                check("hold_ts", 32'(SPK_TS_END), 32'(hold_ts));
            end
            if (SPK_VALID) valid_seen++;
            if (CORE_CLR) begin
                clr_cnt++;
                check("clr_width", 32'(prev_clr), 0);
            end
            prev_clr = CORE_CLR;
            if (SPK_VALID && SPK_READY) begin
                check("event_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    ev_t ev;
                    ev = exp_q.pop_front();
                    check("spk_addr", 32'(SPK_ADDR), 32'(ev.a));
                    check("spk_ts_end", 32'(SPK_TS_END), 32'(ev.ts));
                end
                if (SPK_TS_END) ts_cnt++;
                else begin
                    if (spk_cnt == 0) clr_at_first = clr_cnt;
                    spk_cnt++;
                end
            end
            hold_prev = SPK_VALID && !SPK_READY;
            hold_addr = SPK_ADDR;
            hold_ts   = SPK_TS_END;
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) img[i] = 8'd0;
        img[5] = 8'd200; img[9] = 8'd100; img[20] = 8'd50;

        // Encoder sweep and hand-computed pins of the model.
        for (int p = 0; p < 256; p++) begin
            for (int t = 0; t < 4; t++) begin
                enc_p = 8'(p);
                enc_t = 2'(t);
                #1;
                check("rate_encoder", 32'(enc_s), 32'(model_spike(p, t)));
            end
        end
        check("pin_200_t0", 32'(model_spike(200, 0)), 1);
        check("pin_100_t1", 32'(model_spike(100, 1)), 0);
        check("pin_100_t2", 32'(model_spike(100, 2)), 1);
        check("pin_50_t2", 32'(model_spike(50, 2)), 0);
        check("pin_50_t3", 32'(model_spike(50, 3)), 1);
        check("pin_0_t3", 32'(model_spike(0, 3)), 0);
        build_events();
        check("pin_q_size", 32'(exp_q.size()), 11);
        check("pin_q5_addr", 32'(exp_q[5].a), 9);
        check("pin_q9_addr", 32'(exp_q[9].a), 20);
        check("pin_q10_ts", 32'(exp_q[10].ts), 1);

        tick(3);
        check_all_zero("reset");
        RST = 1'b0;
        tick(2);
        check_all_zero("post_reset");

        // Run 1: always ready; NEW_IMAGE then held high throughout.
        zero_counts();
        NEW_IMAGE = 1'b1;
        tick(1);
        check("run1_clr", 32'(CORE_CLR), 1);
        check("run1_busy", 32'(BUSY), 1);
        wait_ts(4, "run1_ts_count");
        check("run1_spikes", 32'(spk_cnt), 7);
        check("run1_clr_count", 32'(clr_cnt), 1);
        check("run1_clr_before_spike", 32'(clr_at_first), 1);
        tick(5);
        check("wait_busy", 32'(BUSY), 1);
        check("wait_rdy", 32'(COPROCESSOR_RDY), 0);
        pulse_done(8'd5);
        check("run1_rdy", 32'(COPROCESSOR_RDY), 1);
        check("run1_digit", 32'(INFERED_DIGIT), 5);
        check("run1_busy_done", 32'(BUSY), 0);
        for (int k = 0; k < 10; k++) begin
            tick(100);
            if (k == 4) pulse_done(8'd9);
            check("hold_rdy", 32'(COPROCESSOR_RDY), 1);
            check("hold_digit", 32'(INFERED_DIGIT), 5);
            check("hold_busy", 32'(BUSY), 0);
        end
        check("level_single_run_clr", 32'(clr_cnt), 1);

        // Run 2: pseudo-random ready, same event stream expected.
        build_events();
        zero_counts();
        rdy_mode = 1;
        new_edge();
        check("run2_rdy_cleared", 32'(COPROCESSOR_RDY), 0);
        check("run2_clr", 32'(CORE_CLR), 1);
        wait_ts(4, "run2_ts_count");
        check("run2_spikes", 32'(spk_cnt), 7);
        check("run2_clr_count", 32'(clr_cnt), 1);
        rdy_mode = 0;
        tick(2);
        pulse_done(8'd3);
        check("run2_digit", 32'(INFERED_DIGIT), 3);

        // Run 3: restart request during step 1 is deferred until the run completes.
        build_events();
        build_events();
        zero_counts();
        new_edge();
        wait_ts(1, "run3_reach_step1");
        new_edge();
        check("run3_not_restarted", 32'(clr_cnt), 1);
        wait_ts(4, "run3_ts_count");
        check("run3_spikes", 32'(spk_cnt), 7);
        tick(2);
        pulse_done(8'd7);
        check("run3_rdy", 32'(COPROCESSOR_RDY), 1);
        check("run3_digit", 32'(INFERED_DIGIT), 7);
        check("run3_busy_idle", 32'(BUSY), 0);
        tick(1);
        check("run3_rdy_one_cycle", 32'(COPROCESSOR_RDY), 0);
        check("run3_pending_clr", 32'(CORE_CLR), 1);
        check("run3_pending_busy", 32'(BUSY), 1);
        wait_ts(8, "run3b_ts_count");
        check("run3b_spikes", 32'(spk_cnt), 14);
        check("run3b_clr_count", 32'(clr_cnt), 2);
        tick(2);
        pulse_done(8'd2);
        check("run3b_digit", 32'(INFERED_DIGIT), 2);
        check("queue_drained", 32'(exp_q.size()), 0);

        // Run 4: never ready, level-high start, then asynchronous reset while stalled in SEND.
        zero_counts();
        rdy_mode = 2;
        new_edge();
        tick(500);
        check("run4_one_clr", 32'(clr_cnt), 1);
        check("run4_stalled_valid", 32'(SPK_VALID), 1);
        check("run4_stalled_addr", 32'(SPK_ADDR), 5);
        check("run4_stalled_ts", 32'(SPK_TS_END), 0);
        #2;
        RST = 1'b1;
        #1;
        check_all_zero("async_reset");
        NEW_IMAGE = 1'b0;
        rdy_mode  = 0;
        tick(3);
        RST = 1'b0;
        valid_seen = 0;
        zero_counts();
        tick(50);
        check("after_reset_busy", 32'(BUSY), 0);
        check("after_reset_no_valid", 32'(valid_seen), 0);
        check("after_reset_no_clr", 32'(clr_cnt), 0);
        pulse_done(8'd9);
        tick(1);
        check("idle_done_rdy", 32'(COPROCESSOR_RDY), 0);
        check("idle_done_digit", 32'(INFERED_DIGIT), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
